// File: rtl/pix_burst_wr.sv
// pix_burst_wr: buffers camera pixels in a small FIFO and hands them to an SDRAM
// controller as fixed-length write bursts, walking a linear frame buffer.
//
// Parameters:
//   BURST_LEN  - pixels per write burst (power of two, 2..64)
//   FIFO_DEPTH - pixel FIFO entries (power of two, >= 2*BURST_LEN)
//   FRAME_PIX  - pixels per frame (multiple of BURST_LEN)
//   BASE_ADDR  - first SDRAM word address of the frame buffer
//
// Ports:
//   sys_clk, sys_rst_n      - clock, synchronous active-low reset
//   sys_init_done           - system ready; gates pushes and FSM progress
//   frame_start             - frame start pulse (deferred to IDLE)
//   pix_wr_en, pix_data     - incoming pixel strobe and RGB565 data
//   wr_req, wr_ack, wr_addr - burst request handshake and start address
//   wr_data_vld, wr_data    - burst word stream
//   overflow                - sticky pixel-drop flag (cleared by frame start)
//   frame_done              - pulse after the last burst word of a frame
//   frame_cnt               - completed frame count (only with FRAME_CNT_EN)
//
// Build option: define FRAME_CNT_EN to add the 8-bit frame_cnt output.
module pix_burst_wr #(
  parameter int unsigned BURST_LEN  = 8,
  parameter int unsigned FIFO_DEPTH = 32,
  parameter int unsigned FRAME_PIX  = 307200,
  parameter logic [23:0] BASE_ADDR  = 24'd0
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        sys_init_done,
  input  logic        frame_start,
  input  logic        pix_wr_en,
  input  logic [15:0] pix_data,
  output logic        wr_req,
  input  logic        wr_ack,
  output logic [23:0] wr_addr,
  output logic        wr_data_vld,
  output logic [15:0] wr_data,
  output logic        overflow,
`ifdef FRAME_CNT_EN
  output logic [7:0]  frame_cnt,
`endif
  output logic        frame_done
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned BW = $clog2(BURST_LEN);
  localparam logic [23:0] BURST_INC = 24'(BURST_LEN);
  localparam logic [23:0] END_ADDR  = 24'(BASE_ADDR + FRAME_PIX);
  localparam logic [AW:0] FILL_FULL = (AW + 1)'(FIFO_DEPTH);
  localparam logic [AW:0] FILL_BURST = (AW + 1)'(BURST_LEN);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_LEN - 1);

  typedef enum logic [1:0] {StIdle, StReq, StBurst} state_e;

  state_e          state_q, state_d;
  logic [15:0]     mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wptr_q, rptr_q;
  logic [AW:0]     fill_q;
  logic [BW-1:0]   beat_q;
  logic [23:0]     addr_q;
  logic            ovf_q, done_q, pend_q;

  logic            full, push, drop, pop, last_beat, apply_start, wrap;
  logic [23:0]     next_addr;

  always_comb begin
    full        = (fill_q == FILL_FULL);
    apply_start = (state_q == StIdle) && pend_q;
    // Fullness is the registered count, so a same-cycle pop never frees a slot.
    push        = pix_wr_en && sys_init_done && !full && !apply_start;
    drop        = pix_wr_en && sys_init_done && full;
    pop         = (state_q == StBurst);
    last_beat   = pop && (beat_q == LAST_BEAT);
    next_addr   = addr_q + BURST_INC;
    wrap        = (next_addr == END_ADDR);
  end

  // Next-state: a pending frame start holds IDLE so the flush happens first.
  // A burst already running finishes even if sys_init_done drops.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (sys_init_done && !pend_q && (fill_q >= FILL_BURST)) state_d = StReq;
      StReq:   if (sys_init_done && wr_ack) state_d = StBurst;
      StBurst: if (last_beat) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    wr_req      = (state_q == StReq);
    wr_data_vld = pop;
    wr_data     = pop ? mem_q[rptr_q] : 16'h0000;
    wr_addr     = addr_q;
    overflow    = ovf_q;
    frame_done  = done_q;
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q <= StIdle;
      wptr_q  <= '0;
      rptr_q  <= '0;
      fill_q  <= '0;
      beat_q  <= '0;
      addr_q  <= BASE_ADDR;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= last_beat && wrap;
      pend_q  <= frame_start || (pend_q && !apply_start);
      // Beat counter wraps to zero on the last beat since BURST_LEN is 2^BW.
      beat_q  <= pop ? beat_q + 1'b1 : '0;
      if (apply_start) begin
        wptr_q <= '0;
        rptr_q <= '0;
        fill_q <= '0;
        addr_q <= BASE_ADDR;
        ovf_q  <= 1'b0;
      end else begin
        if (push) wptr_q <= wptr_q + 1'b1;
        if (pop)  rptr_q <= rptr_q + 1'b1;
        if (push && !pop)      fill_q <= fill_q + 1'b1;
        else if (pop && !push) fill_q <= fill_q - 1'b1;
        if (drop) ovf_q <= 1'b1;
        if (last_beat) addr_q <= wrap ? BASE_ADDR : next_addr;
      end
    end
  end

  // Storage needs no reset: reads are only exposed while bursting valid words.
  always_ff @(posedge sys_clk) begin
    if (push) mem_q[wptr_q] <= pix_data;
  end

`ifdef FRAME_CNT_EN
  logic [7:0] fcnt_q;

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      fcnt_q <= 8'd0;
    end else if (done_q) begin
      fcnt_q <= fcnt_q + 8'd1;
    end
  end

  assign frame_cnt = fcnt_q;
`endif

endmodule
